// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for the single-port ACDC data memory.
// The core load/store path and the host loader/DMA port share one memory.
// Ownership is round-robin. The current owner parks on the port until the
// other side asks for it. The host may hold a bounded lock for bursts.
// Each ownership hand-off that follows a live transfer costs one bubble cycle.
// Optional feature macro: DMEM_ARB_STATS_EN adds per-requester wait counters.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          CLK,
  input  logic          start,

  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,

  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,

`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   core_wait_ct,
  output logic [15:0]   host_wait_ct,
`endif

  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  // The lock counter only ever needs to reach LOCK_MAX.
  localparam int              LW       = $clog2(LOCK_MAX + 1);
  localparam logic [LW-1:0]   LOCK_LIM = LW'(LOCK_MAX);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  owner_t        owner_q, owner_d;
  logic          bubble_q, bubble_d;
  logic [LW-1:0] lock_ct_q, lock_ct_d;
  logic [LW-1:0] lock_next;

  // Grants are combinational from req. They are blocked in the bubble cycle and while start is high.
  always_comb begin
    core_gnt = core_req & (owner_q == OWN_CORE) & ~bubble_q & ~start;
    host_gnt = host_req & (owner_q == OWN_HOST) & ~bubble_q & ~start;
  end

  // Memory port follows the owner. The non-owner's inputs never reach memory.
  always_comb begin
    DataAddress = '0;
    DataIn      = '0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    if (!start) begin
      if (owner_q == OWN_CORE) begin
        DataAddress = core_addr;
        DataIn      = core_wdata;
        ReadMem     = core_req & ~core_we;
        WriteMem    = core_gnt & core_we;
      end else begin
        DataAddress = host_addr;
        DataIn      = host_wdata;
        ReadMem     = host_req & ~host_we;
        WriteMem    = host_gnt & host_we;
      end
    end
  end

  // The lock count includes a transfer that happens on this edge.
  // The owner switch then lands right after the LOCK_MAX-th locked host grant.
  always_comb begin
    lock_next = lock_ct_q;
    if (host_gnt && core_req && (lock_ct_q != LOCK_LIM)) begin
      lock_next = lock_ct_q + LW'(1);
    end
  end

  // Next-owner selection. A hand-off after a live transfer inserts one bubble.
  // The owner is not re-evaluated during that bubble.
  always_comb begin
    owner_d   = owner_q;
    bubble_d  = 1'b0;
    lock_ct_d = lock_ct_q;
    if (!bubble_q) begin
      if (owner_q == OWN_CORE) begin
        if (host_req) begin
          owner_d   = OWN_HOST;
          bubble_d  = core_gnt;
          lock_ct_d = '0;
        end
      end else begin
        lock_ct_d = lock_next;
        if (host_lock && (lock_next < LOCK_LIM)) begin
          owner_d = OWN_HOST;
        end else if (core_req) begin
          owner_d   = OWN_CORE;
          bubble_d  = host_gnt;
          lock_ct_d = '0;
        end
      end
    end
  end

  // Ownership, bubble and lock state registers.
  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      owner_q   <= OWN_CORE;
      bubble_q  <= 1'b0;
      lock_ct_q <= '0;
    end else begin
      owner_q   <= owner_d;
      bubble_q  <= bubble_d;
      lock_ct_q <= lock_ct_d;
    end
  end

  // Core read return: capture memory data on a read transfer and pulse rvalid for one cycle.
  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      if (core_gnt && !core_we) begin
        core_rdata <= DataOut;
      end
    end
  end

  // Host read return: same as the core side. Data holds until the host's next read.
  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) begin
        host_rdata <= DataOut;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating counts of cycles each requester spends waiting for a grant.
  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      core_wait_ct <= '0;
      host_wait_ct <= '0;
    end else begin
      if (core_req && !core_gnt && (core_wait_ct != 16'hFFFF)) begin
        core_wait_ct <= core_wait_ct + 16'd1;
      end
      if (host_req && !host_gnt && (host_wait_ct != 16'hFFFF)) begin
        host_wait_ct <= host_wait_ct + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, self-checking bench for dmem_arbiter.
// A small behavioural memory sits on the arbiter's memory port.
// Every location starts as addr ^ 8'h3C.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 4;

  logic          CLK = 1'b0;
  logic          start;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] DataAddress;
  logic          ReadMem, WriteMem;
  logic [DW-1:0] DataIn, DataOut;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   core_wait_ct, host_wait_ct;
`endif

  logic [DW-1:0] mem [0:255];
  logic          mem_load;

  int checks = 0;
  int errors = 0;

  // Phase C: both requesters read continuously.
  bit alt_cg  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  bit alt_hg  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  bit alt_crv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit alt_hrv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Phase D: locked host writes while the core reads.
  bit lk_cr  [13] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
  bit lk_cg  [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
  bit lk_hg  [13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  bit lk_crv [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  // Free-running clock with a 10 ns period.
  always #5 CLK = ~CLK;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK         (CLK),
    .start       (start),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
`ifdef DMEM_ARB_STATS_EN
    .core_wait_ct(core_wait_ct),
    .host_wait_ct(host_wait_ct),
`endif
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  // Combinational read of the behavioural memory.
  assign DataOut = mem[DataAddress];

  // Memory preload while mem_load is high; otherwise write when the arbiter asks.
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else if (WriteMem) begin
      mem[DataAddress] <= DataIn;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input logic hr, input logic hw,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                               input logic hl);
    core_req   = cr;
    core_we    = cw;
    core_addr  = ca;
    core_wdata = cd;
    host_req   = hr;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
    host_lock  = hl;
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Phase A: reset, then a single core read of 0x10.
    start    = 1'b1;
    mem_load = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    nextCycle();
    nextCycle();
    mem_load = 1'b0;
    @(negedge CLK);
    checkOutput("rst_core_gnt", 32'(core_gnt), 0);
    checkOutput("rst_host_gnt", 32'(host_gnt), 0);
    checkOutput("rst_readmem", 32'(ReadMem), 0);
    checkOutput("rst_writemem", 32'(WriteMem), 0);
    checkOutput("rst_addr", 32'(DataAddress), 0);
    checkOutput("rst_core_rvalid", 32'(core_rvalid), 0);
    checkOutput("rst_core_rdata", 32'(core_rdata), 0);
    nextCycle();
    start = 1'b0;
    @(negedge CLK);
    checkOutput("a_core_gnt", 32'(core_gnt), 1);
    checkOutput("a_readmem", 32'(ReadMem), 1);
    checkOutput("a_addr", 32'(DataAddress), 'h10);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("a_core_rvalid", 32'(core_rvalid), 1);
    checkOutput("a_core_rdata", 32'(core_rdata), 'h2C);
    checkOutput("a_core_gnt_off", 32'(core_gnt), 0);
    nextCycle();
    @(negedge CLK);
    checkOutput("a_rvalid_pulse", 32'(core_rvalid), 0);
    checkOutput("a_rdata_hold", 32'(core_rdata), 'h2C);

    // Phase B: host writes A5 to 0x20 with the core as owner, then the core reads it back.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b0);
    @(negedge CLK);
    checkOutput("b_host_wait", 32'(host_gnt), 0);
    checkOutput("b_wr_wait", 32'(WriteMem), 0);
    nextCycle();
    @(negedge CLK);
    checkOutput("b_host_gnt", 32'(host_gnt), 1);
    checkOutput("b_writemem", 32'(WriteMem), 1);
    checkOutput("b_datain", 32'(DataIn), 'hA5);
    checkOutput("b_addr", 32'(DataAddress), 'h20);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("b_core_wait", 32'(core_gnt), 0);
    nextCycle();
    @(negedge CLK);
    checkOutput("b_core_gnt", 32'(core_gnt), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("b_core_rvalid", 32'(core_rvalid), 1);
    checkOutput("b_core_rdata", 32'(core_rdata), 'hA5);

    // Phase C: both read continuously. Expect core, bubble, host, bubble, core.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("c_core_gnt[%0d]", i), 32'(core_gnt), 32'(alt_cg[i]));
      checkOutput($sformatf("c_host_gnt[%0d]", i), 32'(host_gnt), 32'(alt_hg[i]));
      checkOutput($sformatf("c_core_rv[%0d]", i), 32'(core_rvalid), 32'(alt_crv[i]));
      checkOutput($sformatf("c_host_rv[%0d]", i), 32'(host_rvalid), 32'(alt_hrv[i]));
      if (alt_crv[i]) checkOutput($sformatf("c_core_rd[%0d]", i), 32'(core_rdata), 'h3D);
      if (alt_hrv[i]) checkOutput($sformatf("c_host_rd[%0d]", i), 32'(host_rdata), 'h3E);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("c_bubble_gnt", 32'(core_gnt | host_gnt), 0);
    checkOutput("c_last_rvalid", 32'(core_rvalid), 1);
    checkOutput("c_last_rdata", 32'(core_rdata), 'h3D);
    nextCycle();

    // Phase D: locked host writes 0x77 to 0x30. The core waits exactly LOCK_MAX grants plus one bubble.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(lk_cr[i], 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h30, 8'h77, 1'b1);
      @(negedge CLK);
      checkOutput($sformatf("d_core_gnt[%0d]", i), 32'(core_gnt), 32'(lk_cg[i]));
      checkOutput($sformatf("d_host_gnt[%0d]", i), 32'(host_gnt), 32'(lk_hg[i]));
      checkOutput($sformatf("d_core_rv[%0d]", i), 32'(core_rvalid), 32'(lk_crv[i]));
      if (lk_crv[i]) checkOutput($sformatf("d_core_rd[%0d]", i), 32'(core_rdata), 'h77);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("d_final_rvalid", 32'(core_rvalid), 1);
    checkOutput("d_final_rdata", 32'(core_rdata), 'h77);
    nextCycle();

    // Phase E: host read of 0x05, then start right after the transfer edge. The rvalid must be cancelled.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("e_host_gnt", 32'(host_gnt), 1);
    nextCycle();
    start = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("e_host_rvalid", 32'(host_rvalid), 0);
    checkOutput("e_host_rdata", 32'(host_rdata), 0);
    checkOutput("e_core_rdata", 32'(core_rdata), 0);
    checkOutput("e_core_gnt", 32'(core_gnt), 0);
    checkOutput("e_readmem", 32'(ReadMem), 0);
    checkOutput("e_addr", 32'(DataAddress), 0);
    nextCycle();
    start = 1'b0;
    @(negedge CLK);
    checkOutput("e_owner_core", 32'(core_gnt), 1);
    checkOutput("e_host_rv_quiet", 32'(host_rvalid), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("e_core_rvalid", 32'(core_rvalid), 1);
    checkOutput("e_core_rdata2", 32'(core_rdata), 'h2C);
    checkOutput("e_host_wait", 32'(host_gnt), 0);
    nextCycle();
    @(negedge CLK);
    checkOutput("e_host_gnt2", 32'(host_gnt), 1);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("e_host_wait_ct", 32'(host_wait_ct), 1);
    checkOutput("e_core_wait_ct", 32'(core_wait_ct), 0);
`endif
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("e_host_rvalid2", 32'(host_rvalid), 1);
    checkOutput("e_host_rdata2", 32'(host_rdata), 'h39);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
